// File: rtl/branch_history_table_pkg.sv
// Shared 2-bit saturating counter encodings and next-state helpers for the branch predictor.
// Pure combinational helpers: zero latency, no flow control.
package branch_history_table_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt2_t;

  function automatic cnt2_t sat_inc(input cnt2_t cur);
    return (cur == ST) ? ST : cnt2_t'(cur + 2'd1);
  endfunction

  function automatic cnt2_t sat_dec(input cnt2_t cur);
    return (cur == SNT) ? SNT : cnt2_t'(cur - 2'd1);
  endfunction

endpackage

// File: rtl/branch_history_table_if.sv
// ID-stage lookup and MEM-stage resolve bundle between the pipeline (master) and the predictor (slave).
// Wires only: zero latency, no backpressure (the predictor accepts every cycle).
interface branch_history_table_if #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
);
  logic             branch_id;
  logic [31:0]      pc_id;
  logic             predict;
  logic [IDX_W-1:0] idx_id;
  logic             upd_valid_mem;
  logic [IDX_W-1:0] upd_idx_mem;
  logic             upd_taken_mem;
  logic             upd_pred_mem;
  logic             mispredict;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output branch_id, pc_id, upd_valid_mem, upd_idx_mem, upd_taken_mem, upd_pred_mem,
    input  predict, idx_id, mispredict, branch_cnt, miss_cnt
  );

  modport slave (
    input  branch_id, pc_id, upd_valid_mem, upd_idx_mem, upd_taken_mem, upd_pred_mem,
    output predict, idx_id, mispredict, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_history_table_sat_counter2.sv
// Next-state function of one 2-bit saturating counter given the resolved outcome.
// Combinational: zero latency, no backpressure.
module sat_counter2
  import branch_history_table_pkg::*;
(
  input  cnt2_t cur,
  input  logic  taken,
  output cnt2_t nxt
);

  assign nxt = taken ? sat_inc(cur) : sat_dec(cur);

endmodule

// File: rtl/branch_history_table.sv
// 2-bit counter branch predictor with optional gshare indexing, trained when branches resolve in MEM.
// Lookup is combinational (0 cycles); training, history, stats and mispredict register at the edge; never stalls.
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int USE_GSHARE = 0,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_history_table_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  cnt2_t            bht [DEPTH];
  cnt2_t            upd_next;
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] pc_idx;
  logic [IDX_W-1:0] lookup_idx;
  logic             mispredict_q;
  logic             upd_miss;
  logic [CNT_W-1:0] branch_q;
  logic [CNT_W-1:0] miss_q;
  logic             unused_pc_bits;

  assign pc_idx         = bus.pc_id[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.pc_id[31:IDX_W+2], bus.pc_id[1:0]};

  generate
    if (USE_GSHARE != 0) begin : g_gshare
      assign lookup_idx = pc_idx ^ ghr;
    end else begin : g_direct
      assign lookup_idx = pc_idx;
    end
  endgenerate

  // Table read is the registered state only; a same-cycle write is seen next cycle.
  assign bus.idx_id  = lookup_idx;
  assign bus.predict = bus.branch_id & bht[lookup_idx][1];

  sat_counter2 u_sat (
    .cur   (bht[bus.upd_idx_mem]),
    .taken (bus.upd_taken_mem),
    .nxt   (upd_next)
  );

  assign upd_miss = bus.upd_valid_mem & (bus.upd_taken_mem != bus.upd_pred_mem);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht[i] <= WNT;
      end
      ghr          <= '0;
      mispredict_q <= 1'b0;
      branch_q     <= '0;
      miss_q       <= '0;
    end else begin
      mispredict_q <= upd_miss;
      if (bus.upd_valid_mem) begin
        bht[bus.upd_idx_mem] <= upd_next;
        ghr                  <= {ghr[IDX_W-2:0], bus.upd_taken_mem};
        if (branch_q != '1) begin
          branch_q <= branch_q + CNT_W'(1);
        end
        if (upd_miss && (miss_q != '1)) begin
          miss_q <= miss_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.mispredict = mispredict_q;
  assign bus.branch_cnt = branch_q;
  assign bus.miss_cnt   = miss_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: directed cases plus random traffic against a counter-array model.
// Three instances: direct-indexed, gshare, and a narrow-stats variant.
module tb_branch_history_table;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  branch_history_table_if #(.IDX_W(6), .CNT_W(16)) if0 ();
  branch_history_table_if #(.IDX_W(6), .CNT_W(16)) ifg ();
  branch_history_table_if #(.IDX_W(6), .CNT_W(4))  ifs ();

  branch_history_table #(.IDX_W(6), .USE_GSHARE(0), .CNT_W(16)) u_dir (.clk(clk), .rst_n(rst_n), .bus(if0));
  branch_history_table #(.IDX_W(6), .USE_GSHARE(1), .CNT_W(16)) u_gsh (.clk(clk), .rst_n(rst_n), .bus(ifg));
  branch_history_table #(.IDX_W(6), .USE_GSHARE(0), .CNT_W(4))  u_sml (.clk(clk), .rst_n(rst_n), .bus(ifs));

  // Model: [0] direct-indexed instance, [1] gshare instance. Counters held as 0..3.
  int m_cnt  [2][64];
  int m_ghr  [2];
  int m_br   [2];
  int m_miss [2];
  int m_mis  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input int k, input logic rst, input logic v, input int ix,
                             input logic t, input logic p);
    if (!rst) begin
      for (int i = 0; i < 64; i++) m_cnt[k][i] = 1;
      m_ghr[k] = 0; m_br[k] = 0; m_miss[k] = 0; m_mis[k] = 0;
    end else begin
      m_mis[k] = (v && (t != p)) ? 1 : 0;
      if (v) begin
        m_cnt[k][ix] = t ? ((m_cnt[k][ix] < 3) ? m_cnt[k][ix] + 1 : 3)
                         : ((m_cnt[k][ix] > 0) ? m_cnt[k][ix] - 1 : 0);
        m_ghr[k] = ((m_ghr[k] * 2) + (t ? 1 : 0)) % 64;
        if (m_br[k] < 65535) m_br[k]++;
        if ((t != p) && (m_miss[k] < 65535)) m_miss[k]++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_apply(0, rst_n, if0.upd_valid_mem, int'(if0.upd_idx_mem), if0.upd_taken_mem, if0.upd_pred_mem);
    model_apply(1, rst_n, ifg.upd_valid_mem, int'(ifg.upd_idx_mem), ifg.upd_taken_mem, ifg.upd_pred_mem);
    #1;
  endtask

  task automatic drv(input logic b, input logic [31:0] pc, input logic v, input logic [5:0] ix,
                     input logic t, input logic p);
    if0.branch_id = b; if0.pc_id = pc; if0.upd_valid_mem = v;
    if0.upd_idx_mem = ix; if0.upd_taken_mem = t; if0.upd_pred_mem = p;
    ifg.branch_id = b; ifg.pc_id = pc; ifg.upd_valid_mem = v;
    ifg.upd_idx_mem = ix; ifg.upd_taken_mem = t; ifg.upd_pred_mem = p;
  endtask

  task automatic check_lookup();
    int i0, ig;
    i0 = int'(if0.pc_id[7:2]);
    ig = int'(ifg.pc_id[7:2]) ^ m_ghr[1];
    chk("idx_dir",  32'(if0.idx_id),  32'(i0));
    chk("pred_dir", 32'(if0.predict), 32'(if0.branch_id && (m_cnt[0][i0] >= 2)));
    chk("idx_gsh",  32'(ifg.idx_id),  32'(ig));
    chk("pred_gsh", 32'(ifg.predict), 32'(ifg.branch_id && (m_cnt[1][ig] >= 2)));
  endtask

  task automatic check_regs();
    chk("mis_dir",  32'(if0.mispredict), 32'(m_mis[0]));
    chk("br_dir",   32'(if0.branch_cnt), 32'(m_br[0]));
    chk("miss_dir", 32'(if0.miss_cnt),   32'(m_miss[0]));
    chk("mis_gsh",  32'(ifg.mispredict), 32'(m_mis[1]));
    chk("br_gsh",   32'(ifg.branch_cnt), 32'(m_br[1]));
    chk("miss_gsh", 32'(ifg.miss_cnt),   32'(m_miss[1]));
  endtask

  initial begin
    int s_miss;
    logic t, p;

    ifs.branch_id = 1'b0; ifs.pc_id = '0; ifs.upd_valid_mem = 1'b0;
    ifs.upd_idx_mem = '0; ifs.upd_taken_mem = 1'b0; ifs.upd_pred_mem = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) model_apply(k, 1'b0, 0, 0, 0, 0);

    // Reset then first lookup returns weak-NT
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_regs();
    chk("rst_br", 32'(if0.branch_cnt), 32'h0);
    drv(1, 32'h40, 0, 0, 0, 0);
    #3;
    check_lookup();
    chk("rst_pred", 32'(if0.predict), 32'h0);
    chk("rst_idx",  32'(if0.idx_id),  32'h10);

    // Saturation up and down at index 0x10
    drv(0, 0, 1, 6'h10, 1, 1);
    cycle(); cycle();
    drv(1, 32'h40, 0, 0, 0, 0);
    #3;
    chk("sat_t2", 32'(if0.predict), 32'h1);
    drv(1, 32'h40, 1, 6'h10, 1, 1);
    cycle();
    drv(1, 32'h40, 0, 0, 0, 0);
    #3;
    chk("sat_t3", 32'(if0.predict), 32'h1);
    drv(0, 0, 1, 6'h10, 0, 0);
    cycle(); cycle(); cycle();
    drv(1, 32'h40, 1, 6'h10, 1, 1);
    #3;
    chk("sat_nt3", 32'(if0.predict), 32'h0);
    cycle();
    drv(1, 32'h40, 0, 0, 0, 0);
    #3;
    chk("sat_floor", 32'(if0.predict), 32'h0);
    check_regs();

    // Same-cycle read of the entry being written, and the mispredict pulse
    drv(1, 32'h14, 1, 6'h05, 1, 0);
    #3;
    check_lookup();
    chk("rw_same", 32'(if0.predict), 32'h0);
    cycle();
    chk("mis_pulse", 32'(if0.mispredict), 32'h1);
    drv(1, 32'h14, 0, 0, 0, 0);
    #3;
    chk("rw_next", 32'(if0.predict), 32'h1);
    cycle();
    chk("mis_clear", 32'(if0.mispredict), 32'h0);

    // Reset overrides a concurrent update; then stats from a clean start
    rst_n = 1'b0;
    drv(0, 0, 1, 6'h09, 1, 0);
    cycle();
    rst_n = 1'b1;
    check_regs();
    chk("rst_wins_br", 32'(if0.branch_cnt), 32'h0);
    cycle();
    chk("miss_one",  32'(if0.miss_cnt),   32'h1);
    chk("br_one",    32'(if0.branch_cnt), 32'h1);
    drv(0, 0, 1, 6'h09, 1, 1);
    cycle();
    chk("no_pulse", 32'(if0.mispredict), 32'h0);
    chk("br_two",   32'(if0.branch_cnt), 32'h2);
    chk("miss_hold", 32'(if0.miss_cnt),  32'h1);
    check_regs();

    // Gshare: history T,T,N gives ...110
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    cycle();
    rst_n = 1'b1;
    drv(0, 0, 1, 6'h00, 1, 1); cycle();
    drv(0, 0, 1, 6'h00, 1, 1); cycle();
    drv(0, 0, 1, 6'h00, 0, 0); cycle();
    drv(1, 32'h40, 0, 0, 0, 0);
    #3;
    chk("gshare_idx", 32'(ifg.idx_id), 32'h16);
    check_lookup();

    // Narrow stats saturate at 0xF
    s_miss = 0;
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      t = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      if (t != p) s_miss++;
      ifs.upd_valid_mem = 1'b1; ifs.upd_idx_mem = 6'($urandom_range(0, 63));
      ifs.upd_taken_mem = t; ifs.upd_pred_mem = p;
      cycle();
    end
    chk("stat_sat_br",   32'(ifs.branch_cnt), 32'hF);
    chk("stat_sat_miss", 32'(ifs.miss_cnt),   32'((s_miss > 15) ? 15 : s_miss));

    // Reset with an update pending: all entries back to weak-NT, stats cleared
    rst_n = 1'b0;
    ifs.upd_taken_mem = 1'b1; ifs.upd_pred_mem = 1'b0;
    cycle();
    rst_n = 1'b1;
    ifs.upd_valid_mem = 1'b0;
    chk("rst_sml_br",   32'(ifs.branch_cnt), 32'h0);
    chk("rst_sml_miss", 32'(ifs.miss_cnt),   32'h0);
    chk("rst_sml_mis",  32'(ifs.mispredict), 32'h0);
    for (int i = 0; i < 64; i++) begin
      ifs.branch_id = 1'b1; ifs.pc_id = 32'(i) << 2;
      drv(1, 32'(i) << 2, 0, 0, 0, 0);
      #1;
      chk("rst_tbl_sml", 32'(ifs.predict), 32'h0);
      check_lookup();
    end
    // One taken step from weak-NT must reach weak-T everywhere
    for (int i = 0; i < 64; i++) begin
      ifs.upd_valid_mem = 1'b1; ifs.upd_idx_mem = 6'(i);
      ifs.upd_taken_mem = 1'b1; ifs.upd_pred_mem = 1'b1;
      cycle();
    end
    ifs.upd_valid_mem = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ifs.pc_id = 32'(i) << 2;
      #1;
      chk("tbl_wnt_step", 32'(ifs.predict), 32'h1);
    end
    ifs.branch_id = 1'b0;

    // Random traffic with clustered indices and occasional resets
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      drv(1'($urandom_range(0, 1)),
          ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2),
          1'($urandom_range(0, 3) != 0),
          6'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
      #3;
      check_lookup();
      cycle();
      check_regs();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
